bram_arb: RTL and testbench
===========================

// Module: bram_arb
// PURPOSE
//  Shares the single backup-RAM port (bram) between the RAM-cart CPU path and
//  the MCU save-sync path. Sequences each access over a fixed-latency memory.
//  Tracks cart writes (dirty flag, write counter) so the MCU knows when to flush saves.
//  Sits between ram_cart's mem_* port and MapOut.bram / MapIn.bram_do in the map_cdb mapper.
// PARAMETERS
//  MEM_LAT  2  cycles per memory access (strobes held MEM_LAT cycles, read data sampled on last); legal 1..15
//  AW       18 word address width (covers RAMCART256)
// PORTS
//  clk         in   1   system clock (mai.clk)
//  rst_n       in   1   async active-low reset
//  cart_addr   in   AW  cart word address
//  cart_din    in   16  cart write data
//  cart_oe     in   1   cart read strobe (level)
//  cart_we_lo  in   1   cart write low byte (level)
//  cart_we_hi  in   1   cart write high byte (level)
//  cart_dout   out  16  cart read data, valid while cart_rdy
//  cart_rdy    out  1   cart access complete; held until all cart strobes low
//  mcu_req     in   1   MCU request (level, held until mcu_ack)
//  mcu_we      in   1   1=write both bytes, 0=read
//  mcu_addr    in   AW  MCU word address
//  mcu_din     in   16  MCU write data
//  mcu_dout    out  16  MCU read data, valid from mcu_ack until next MCU access
//  mcu_ack     out  1   one-cycle completion pulse
//  mem_addr    out  AW  to bram.addr
//  mem_dati    out  16  to bram.dati
//  mem_dato    in   16  from bram.dato
//  mem_oe      out  1   memory read enable
//  mem_we_lo   out  1   memory write low byte
//  mem_we_hi   out  1   memory write high byte
//  dirty       out  1   set by any cart write, cleared by dirty_clr
//  dirty_clr   in   1   one-cycle clear from MCU
//  wr_cnt      out  16  completed cart writes, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, cart_srv=0, last_cart=0.
//  - cart_act = cart_oe|cart_we_lo|cart_we_hi. cart_pend = cart_act & !cart_srv.
//  - cart_srv: set on entry to CART_DONE; cleared when cart_act=0.
//    Gives one memory access per strobe assertion.
//  - Cart inputs (addr, din, strobes) are latched on grant. They are not re-sampled mid-access.
//  - FSM states:
//      IDLE:      grant cart if cart_pend and !(last_cart & mcu_req), else MCU if mcu_req, else stay.
//      CART:      drive latched addr/data/strobes for MEM_LAT cycles, then go to CART_DONE.
//      CART_DONE: cart_rdy=1 and cart_dout holds data. Leave to IDLE when cart_act=0.
//                 An MCU access may not start here; it starts only from IDLE.
//      MCU:       drive for MEM_LAT cycles (we_lo=we_hi=mcu_we, oe=!mcu_we).
//                 Then mcu_ack=1 for 1 cycle and go to IDLE.
//  - Fairness: last_cart=1 after a cart grant, 0 after an MCU grant.
//    Cart wins ties unless it also won the previous grant. Max MCU wait is one cart access.
//  - Mem strobes are asserted only in CART/MCU. mem_oe and mem_we_* are never both 1.
//  - Read data: mem_dato is captured on the last access cycle into cart_dout or mcu_dout.
//  - Cart write with either byte strobe: on leaving CART, dirty<=1 and wr_cnt<=wr_cnt+1 (mod 2^16).
//  - dirty_clr in the same cycle as a dirty set: the set wins.
//  - Cart strobes dropping mid-access: the access still completes. CART_DONE then exits next cycle.
//  - mcu_req dropped before ack: the access still completes and ack still pulses. No abort.
//  - Async reset mid-access: strobes drop immediately, no ack, and dirty/wr_cnt are cleared.
// TESTING
//  1 Cart read: addr 0x00123, mem returns 0xBEEF -> mem_oe high 2 cycles; cart_rdy on 3rd cycle, cart_dout=0xBEEF; rdy drops 1 cycle after oe low.
//  2 MCU write: addr 0x3FFFF, data 0x1234 -> mem_we_lo=we_hi=1 for 2 cycles; mcu_ack single pulse; dirty stays 0, wr_cnt 0.
//  3 Cart and MCU requesting same cycle, last_cart=0 -> cart granted first; MCU granted immediately after cart strobes drop; ack follows.
//  4 Back-to-back cart reads with mcu_req held -> cart, MCU, cart grant sequence; no MCU wait over one cart access.
//  5 Cart we_hi only x3, then dirty_clr -> mem_we_hi only; wr_cnt=3, dirty=1, then 0; wr_cnt 0xFFFF + write -> 0x0000.
//  6 rst_n low during MCU read cycle 1 -> all mem strobes 0 at once, no mcu_ack; after release FSM=IDLE and a new request is served.

Source files
------------

// File: rtl/bram_arb_if.sv
// Signal bundle for bram_arb: cart client, MCU client, backup-RAM port and save-tracking status.
// The slave modport is the arbiter's view; master is the view of the surrounding clients and memory.
interface bram_arb_if #(
  parameter int AW = 18
);
  logic [AW-1:0] cart_addr;
  logic [15:0]   cart_din;
  logic          cart_oe;
  logic          cart_we_lo;
  logic          cart_we_hi;
  logic [15:0]   cart_dout;
  logic          cart_rdy;

  logic          mcu_req;
  logic          mcu_we;
  logic [AW-1:0] mcu_addr;
  logic [15:0]   mcu_din;
  logic [15:0]   mcu_dout;
  logic          mcu_ack;

  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_dati;
  logic [15:0]   mem_dato;
  logic          mem_oe;
  logic          mem_we_lo;
  logic          mem_we_hi;

  logic          dirty;
  logic          dirty_clr;
  logic [15:0]   wr_cnt;

  modport slave (
    input  cart_addr, cart_din, cart_oe, cart_we_lo, cart_we_hi,
    output cart_dout, cart_rdy,
    input  mcu_req, mcu_we, mcu_addr, mcu_din,
    output mcu_dout, mcu_ack,
    output mem_addr, mem_dati, mem_oe, mem_we_lo, mem_we_hi,
    input  mem_dato,
    output dirty, wr_cnt,
    input  dirty_clr
  );

  modport master (
    output cart_addr, cart_din, cart_oe, cart_we_lo, cart_we_hi,
    input  cart_dout, cart_rdy,
    output mcu_req, mcu_we, mcu_addr, mcu_din,
    input  mcu_dout, mcu_ack,
    input  mem_addr, mem_dati, mem_oe, mem_we_lo, mem_we_hi,
    output mem_dato,
    input  dirty, wr_cnt,
    output dirty_clr
  );
endinterface

// File: rtl/bram_arb.sv
// Backup-RAM arbiter: time-shares one fixed-latency memory port between the RAM-cart CPU path
// and the MCU save-sync path, alternating grants on contention and tracking cart writes.
module bram_arb #(
  parameter int MEM_LAT = 2
) (
  input logic      clk,
  input logic      rst_n,
  bram_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CART, CART_DONE, MCU} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       cart_srv;
  logic       last_cart;
  logic       cart_act;
  logic       cart_pend;
  logic       cart_wr;
  logic       mcu_pend;

  assign cart_act  = bus.cart_oe | bus.cart_we_lo | bus.cart_we_hi;
  assign cart_pend = cart_act & ~cart_srv;
  assign cart_wr   = bus.cart_we_lo | bus.cart_we_hi;
  // During the ack cycle the MCU still holds the request it is being acked for.
  assign mcu_pend  = bus.mcu_req & ~bus.mcu_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cart_srv      <= 1'b0;
      last_cart     <= 1'b0;
      bus.cart_dout <= '0;
      bus.cart_rdy  <= 1'b0;
      bus.mcu_dout  <= '0;
      bus.mcu_ack   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_dati  <= '0;
      bus.mem_oe    <= 1'b0;
      bus.mem_we_lo <= 1'b0;
      bus.mem_we_hi <= 1'b0;
      bus.dirty     <= 1'b0;
      bus.wr_cnt    <= '0;
    end else begin
      bus.mcu_ack <= 1'b0;
      if (bus.dirty_clr) bus.dirty <= 1'b0;
      if (!cart_act)     cart_srv  <= 1'b0;

      case (state)
        IDLE: begin
          if (cart_pend && !(last_cart && mcu_pend)) begin
            state         <= CART;
            last_cart     <= 1'b1;
            cnt           <= LAT_M1;
            bus.mem_addr  <= bus.cart_addr;
            bus.mem_dati  <= bus.cart_din;
            bus.mem_we_lo <= bus.cart_we_lo;
            bus.mem_we_hi <= bus.cart_we_hi;
            // A write strobe overrides a simultaneous read so oe and we never overlap.
            bus.mem_oe    <= bus.cart_oe & ~cart_wr;
          end else if (mcu_pend) begin
            state         <= MCU;
            last_cart     <= 1'b0;
            cnt           <= LAT_M1;
            bus.mem_addr  <= bus.mcu_addr;
            bus.mem_dati  <= bus.mcu_din;
            bus.mem_we_lo <= bus.mcu_we;
            bus.mem_we_hi <= bus.mcu_we;
            bus.mem_oe    <= ~bus.mcu_we;
          end
        end

        CART: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (bus.mem_oe) bus.cart_dout <= bus.mem_dato;
            if (bus.mem_we_lo || bus.mem_we_hi) begin
              bus.dirty  <= 1'b1;
              bus.wr_cnt <= bus.wr_cnt + 16'd1;
            end
            bus.mem_oe    <= 1'b0;
            bus.mem_we_lo <= 1'b0;
            bus.mem_we_hi <= 1'b0;
            bus.cart_rdy  <= 1'b1;
            cart_srv      <= 1'b1;
            state         <= CART_DONE;
          end
        end

        CART_DONE: begin
          if (!cart_act) begin
            bus.cart_rdy <= 1'b0;
            state        <= IDLE;
          end
        end

        MCU: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (bus.mem_oe) bus.mcu_dout <= bus.mem_dato;
            bus.mem_oe    <= 1'b0;
            bus.mem_we_lo <= 1'b0;
            bus.mem_we_hi <= 1'b0;
            bus.mcu_ack   <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arb.sv
// Directed bench for bram_arb: per-cycle vector table for the arbitration sequences,
// plus hand-written sequences for counter wrap, set-over-clear and mid-access reset.
module tb_bram_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dato_val = 16'h0000;

  bram_arb_if #(.AW(18)) bus ();
  bram_arb #(.MEM_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  assign bus.mem_dato = dato_val;

  int errors = 0;
  int checks = 0;
  int excl_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (bus.mem_oe && (bus.mem_we_lo || bus.mem_we_hi)) excl_viol++;

  // Inputs applied before a rising edge; exp = {mem_oe, mem_we_lo, mem_we_hi, cart_rdy, mcu_ack, dirty} after it.
  typedef struct {
    logic        c_oe;
    logic        c_lo;
    logic        c_hi;
    logic        m_req;
    logic        m_we;
    logic        clr;
    logic [15:0] dato;
    logic [5:0]  exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic c_oe, input logic c_lo, input logic c_hi, input logic m_req,
                     input logic m_we, input logic clr, input logic [15:0] dato, input logic [5:0] exp);
    vec_t v;
    v.c_oe = c_oe; v.c_lo = c_lo; v.c_hi = c_hi; v.m_req = m_req;
    v.m_we = m_we; v.clr = clr; v.dato = dato; v.exp = exp;
    tv.push_back(v);
  endtask

  function automatic logic [5:0] outs();
    return {bus.mem_oe, bus.mem_we_lo, bus.mem_we_hi, bus.cart_rdy, bus.mcu_ack, bus.dirty};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    int cyc;
    logic got_ack;

    bus.cart_addr = '0; bus.cart_din = '0; bus.cart_oe = 0; bus.cart_we_lo = 0; bus.cart_we_hi = 0;
    bus.mcu_req = 0; bus.mcu_we = 0; bus.mcu_addr = '0; bus.mcu_din = '0; bus.dirty_clr = 0;

    // Test 1: cart read 0x00123 returning 0xBEEF
    add(1,0,0, 0,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 0,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 0,0,0, 16'hBEEF, 6'b000100);
    add(0,0,0, 0,0,0, 16'hBEEF, 6'b000000);
    // Test 2: MCU write
    add(0,0,0, 1,1,0, 16'hBEEF, 6'b011000);
    add(0,0,0, 1,1,0, 16'hBEEF, 6'b011000);
    add(0,0,0, 1,1,0, 16'hBEEF, 6'b000010);
    add(0,0,0, 0,0,0, 16'hBEEF, 6'b000000);
    // Test 3: simultaneous cart read and MCU read, last grant was MCU
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b000100);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b000000);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b100000);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b100000);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b000010);
    add(0,0,0, 0,0,0, 16'hC0DE, 6'b000000);
    // Test 4: back-to-back cart reads with MCU request held: cart, MCU, cart, MCU
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b000100);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b000000);
    add(1,0,0, 1,0,0, 16'hC0DE, 6'b100000);
    add(1,0,0, 1,0,0, 16'hC0DE, 6'b100000);
    add(1,0,0, 1,0,0, 16'hC0DE, 6'b000010);
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b100000);
    add(1,0,0, 1,0,0, 16'hBEEF, 6'b000100);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b000000);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b100000);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b100000);
    add(0,0,0, 1,0,0, 16'hC0DE, 6'b000010);
    add(0,0,0, 0,0,0, 16'hC0DE, 6'b000000);
    // Test 5: three high-byte cart writes, then dirty_clr
    for (int i = 0; i < 3; i++) begin
      add(0,0,1, 0,0,0, 16'h0000, (i == 0) ? 6'b001000 : 6'b001001);
      add(0,0,1, 0,0,0, 16'h0000, (i == 0) ? 6'b001000 : 6'b001001);
      add(0,0,1, 0,0,0, 16'h0000, 6'b000101);
      add(0,0,0, 0,0,0, 16'h0000, 6'b000001);
    end
    add(0,0,0, 0,0,1, 16'h0000, 6'b000000);
    // Cart read strobe dropped after one cycle still completes
    add(1,0,0, 0,0,0, 16'h1357, 6'b100000);
    add(0,0,0, 0,0,0, 16'h1357, 6'b100000);
    add(0,0,0, 0,0,0, 16'h1357, 6'b000100);
    add(0,0,0, 0,0,0, 16'h1357, 6'b000000);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs", 32'(outs()), 32'h0);
    check("rst_wr_cnt", 32'(bus.wr_cnt), 32'h0);
    check("rst_cart_dout", 32'(bus.cart_dout), 32'h0);
    check("rst_mcu_dout", 32'(bus.mcu_dout), 32'h0);
    rst_n = 1'b1;
    bus.cart_addr = 18'h00123; bus.cart_din = 16'hA5A5;
    bus.mcu_addr  = 18'h3FFFF; bus.mcu_din  = 16'h1234;
    @(negedge clk);

    foreach (tv[i]) begin
      bus.cart_oe = tv[i].c_oe; bus.cart_we_lo = tv[i].c_lo; bus.cart_we_hi = tv[i].c_hi;
      bus.mcu_req = tv[i].m_req; bus.mcu_we = tv[i].m_we; bus.dirty_clr = tv[i].clr;
      dato_val = tv[i].dato;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tv[i].exp));
    end

    check("cart_dout_last", 32'(bus.cart_dout), 32'h1357);
    check("mcu_dout_last", 32'(bus.mcu_dout), 32'hC0DE);
    check("wr_cnt_3", 32'(bus.wr_cnt), 32'd3);
    check("mem_addr_cart", 32'(bus.mem_addr), 32'h00123);

    // Counter wrap, with dirty_clr on the same edge that sets dirty
    force bus.wr_cnt = 16'hFFFF;
    #1;
    release bus.wr_cnt;
    bus.cart_we_lo = 1'b1;
    @(posedge clk); @(negedge clk);
    check("wrap_we", {29'd0, bus.mem_oe, bus.mem_we_lo, bus.mem_we_hi}, 32'b010);
    check("wrap_dati", 32'(bus.mem_dati), 32'hA5A5);
    @(posedge clk); @(negedge clk);
    bus.dirty_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.dirty_clr = 1'b0;
    bus.cart_we_lo = 1'b0;
    check("wrap_cnt", 32'(bus.wr_cnt), 32'h0);
    check("set_beats_clr", 32'(bus.dirty), 32'h1);
    check("wrap_rdy", 32'(bus.cart_rdy), 32'h1);
    @(posedge clk); @(negedge clk);
    check("wrap_rdy_drop", 32'(bus.cart_rdy), 32'h0);

    // Reset during the first cycle of an MCU read
    bus.mcu_req = 1'b1; bus.mcu_we = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_oe", 32'(bus.mem_oe), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_async_strobes", {29'd0, bus.mem_oe, bus.mem_we_lo, bus.mem_we_hi}, 32'h0);
    check("rst_async_dirty", 32'(bus.dirty), 32'h0);
    check("rst_async_wr_cnt", 32'(bus.wr_cnt), 32'h0);
    bus.mcu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mcu_ack) acks++;
    end
    check("rst_no_ack", 32'(acks), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // New MCU write after reset release
    bus.mcu_req = 1'b1; bus.mcu_we = 1'b1;
    got_ack = 1'b0;
    cyc = 0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("post_rst_addr", 32'(bus.mem_addr), 32'h3FFFF);
        check("post_rst_dati", 32'(bus.mem_dati), 32'h1234);
        check("post_rst_we", {29'd0, bus.mem_oe, bus.mem_we_lo, bus.mem_we_hi}, 32'b011);
      end
      if (bus.mcu_ack) got_ack = 1'b1;
    end
    check("post_rst_ack", 32'(got_ack), 32'h1);
    check("post_rst_ack_cycle", 32'(cyc), 32'd3);
    bus.mcu_req = 1'b0;
    @(negedge clk);
    check("post_rst_ack_pulse", 32'(bus.mcu_ack), 32'h0);
    check("post_rst_wr_cnt", 32'(bus.wr_cnt), 32'h0);
    check("oe_we_exclusive", 32'(excl_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
